// File: rtl/vga_rx.sv
// vga_rx: capture side of the VGA link.
//
// Samples hsync/vsync/blank/RGB in the pixel clock domain, measures the incoming
// timing, locks once two consecutive frames measure identically, and then emits a
// coordinate-tagged pixel stream.
//
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   hsync_i, vsync_i    active-low syncs
//   blank_i             high = valid colour on red_i/green_i/blue_i
//   data_o              pixel {blue, green, red}, with data_valid_o, x_o, y_o
//   sof_o, eol_o        first pixel of frame, last pixel of line
//   htotal_o .. vactive_o  shadowed timing measurements
//   locked_o, lost_o    lock status, one-cycle pulse when lock drops
module vga_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        blank_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic [11:0] data_o,
  output logic        data_valid_o,
  output logic [10:0] x_o,
  output logic [9:0]  y_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic [10:0] htotal_o,
  output logic [7:0]  hpulse_o,
  output logic [10:0] hactive_o,
  output logic [9:0]  vtotal_o,
  output logic [3:0]  vpulse_o,
  output logic [9:0]  vactive_o,
  output logic        locked_o,
  output logic        lost_o
);

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  localparam logic [10:0] HMax = 11'd2047;
  localparam logic [9:0]  VMax = 10'd1023;

  // Two-stage input pipeline; edges are seen between stage q and qq.
  logic        hs_q, hs_qq, vs_q, vs_qq, bl_q, bl_qq;
  logic [11:0] rgb_q, rgb_qq;
  logic        hfall, vfall;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q   <= 1'b0;
      hs_qq  <= 1'b0;
      vs_q   <= 1'b0;
      vs_qq  <= 1'b0;
      bl_q   <= 1'b0;
      bl_qq  <= 1'b0;
      rgb_q  <= '0;
      rgb_qq <= '0;
    end else begin
      hs_q   <= hsync_i;
      hs_qq  <= hs_q;
      vs_q   <= vsync_i;
      vs_qq  <= vs_q;
      bl_q   <= blank_i;
      bl_qq  <= bl_q;
      rgb_q  <= {blue_i, green_i, red_i};
      rgb_qq <= rgb_q;
    end
  end

  assign hfall = hs_qq & ~hs_q;
  assign vfall = vs_qq & ~vs_q;

  // Line and frame measurement counters.
  logic [10:0] hcnt_q, hcnt_d;
  logic [7:0]  hp_cnt_q, hp_cnt_d;
  logic [10:0] ha_cnt_q, ha_cnt_d;
  logic [10:0] line_htot_q, line_htot_d;
  logic [7:0]  line_hp_q, line_hp_d;
  logic [10:0] line_hact_q, line_hact_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [3:0]  vp_cnt_q, vp_cnt_d;
  logic [9:0]  va_cnt_q, va_cnt_d;
  logic        line_has_act;

  assign line_has_act = hfall && (ha_cnt_q != 11'd0);

  always_comb begin
    hcnt_d      = hcnt_q;
    hp_cnt_d    = hp_cnt_q;
    ha_cnt_d    = ha_cnt_q;
    line_htot_d = line_htot_q;
    line_hp_d   = line_hp_q;
    line_hact_d = line_hact_q;
    vcnt_d      = vcnt_q;
    vp_cnt_d    = vp_cnt_q;
    va_cnt_d    = va_cnt_q;

    if (hfall) begin
      // The hfall cycle is itself the first hsync-low cycle of the new line.
      hcnt_d      = 11'd0;
      hp_cnt_d    = 8'd1;
      ha_cnt_d    = {10'd0, bl_q};
      line_htot_d = (hcnt_q == HMax) ? HMax : hcnt_q + 11'd1;
      line_hp_d   = hp_cnt_q;
      if (line_has_act) begin
        line_hact_d = ha_cnt_q;
      end
    end else begin
      if (hcnt_q != HMax) begin
        hcnt_d = hcnt_q + 11'd1;
      end
      if (!hs_q && hp_cnt_q != 8'hff) begin
        hp_cnt_d = hp_cnt_q + 8'd1;
      end
      if (bl_q && ha_cnt_q != HMax) begin
        ha_cnt_d = ha_cnt_q + 11'd1;
      end
    end

    if (vfall) begin
      // vfall wins over a coincident hfall, so the frame restarts at line 0.
      vcnt_d   = 10'd0;
      vp_cnt_d = 4'd1;
      va_cnt_d = 10'd0;
    end else begin
      if (hfall && vcnt_q != VMax) begin
        vcnt_d = vcnt_q + 10'd1;
      end
      if (hfall && !vs_q && vp_cnt_q != 4'hf) begin
        vp_cnt_d = vp_cnt_q + 4'd1;
      end
      if (line_has_act && va_cnt_q != VMax) begin
        va_cnt_d = va_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q      <= '0;
      hp_cnt_q    <= '0;
      ha_cnt_q    <= '0;
      line_htot_q <= '0;
      line_hp_q   <= '0;
      line_hact_q <= '0;
      vcnt_q      <= '0;
      vp_cnt_q    <= '0;
      va_cnt_q    <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      hp_cnt_q    <= hp_cnt_d;
      ha_cnt_q    <= ha_cnt_d;
      line_htot_q <= line_htot_d;
      line_hp_q   <= line_hp_d;
      line_hact_q <= line_hact_d;
      vcnt_q      <= vcnt_d;
      vp_cnt_q    <= vp_cnt_d;
      va_cnt_q    <= va_cnt_d;
    end
  end

  // Frame measurements as seen at vfall; a line ending on the vfall cycle still
  // belongs to the frame that is closing.
  logic [9:0] f_vtot, f_vact;
  assign f_vtot = (vcnt_q == VMax) ? VMax : vcnt_q + 10'd1;
  assign f_vact = (line_has_act && va_cnt_q != VMax) ? va_cnt_q + 10'd1 : va_cnt_q;

  // Shadow registers and lock state machine.
  state_e      state_q;
  logic        locked_q, lost_q;
  logic [10:0] htotal_q, hactive_q;
  logic [7:0]  hpulse_q;
  logic [9:0]  vtotal_q, vactive_q;
  logic [3:0]  vpulse_q;
  logic        frame_match, timeout;

  assign frame_match = {line_htot_d, line_hp_d, line_hact_d, f_vtot, vp_cnt_q, f_vact} ==
                       {htotal_q, hpulse_q, hactive_q, vtotal_q, vpulse_q, vactive_q};
  assign timeout = (hcnt_q == HMax) || (vcnt_q == VMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StSearch;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
      htotal_q  <= '0;
      hpulse_q  <= '0;
      hactive_q <= '0;
      vtotal_q  <= '0;
      vpulse_q  <= '0;
      vactive_q <= '0;
    end else begin
      lost_q <= 1'b0;
      if (vfall) begin
        htotal_q  <= line_htot_d;
        hpulse_q  <= line_hp_d;
        hactive_q <= line_hact_d;
        vtotal_q  <= f_vtot;
        vpulse_q  <= vp_cnt_q;
        vactive_q <= f_vact;
      end
      if (timeout) begin
        state_q  <= StSearch;
        locked_q <= 1'b0;
        lost_q   <= (state_q == StLocked);
      end else if (vfall) begin
        case (state_q)
          StSearch:  state_q <= StMeasure;
          StMeasure: state_q <= StVerify;
          StVerify: begin
            if (frame_match) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
          StLocked: begin
            if (!frame_match) begin
              state_q  <= StVerify;
              locked_q <= 1'b0;
              lost_q   <= 1'b1;
            end
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

  // Pixel stream; coordinates track every blank-high run so they are already
  // aligned when lock is reached at a frame boundary.
  logic        pix_en, eol_c;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic [11:0] data_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        valid_q, sof_q, eol_q;

  assign pix_en = (state_q == StLocked) & bl_qq;
  assign eol_c  = bl_qq & ~bl_q;

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (vfall) begin
      x_cnt_d = 11'd0;
      y_cnt_d = 10'd0;
    end else if (bl_qq) begin
      if (eol_c) begin
        x_cnt_d = 11'd0;
        if (y_cnt_q != VMax) begin
          y_cnt_d = y_cnt_q + 10'd1;
        end
      end else if (x_cnt_q != HMax) begin
        x_cnt_d = x_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      valid_q <= pix_en;
      eol_q   <= pix_en & eol_c;
      sof_q   <= pix_en && (x_cnt_q == 11'd0) && (y_cnt_q == 10'd0);
      if (pix_en) begin
        data_q <= rgb_qq;
        x_q    <= x_cnt_q;
        y_q    <= y_cnt_q;
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign sof_o        = sof_q;
  assign eol_o        = eol_q;
  assign htotal_o     = htotal_q;
  assign hpulse_o     = hpulse_q;
  assign hactive_o    = hactive_q;
  assign vtotal_o     = vtotal_q;
  assign vpulse_o     = vpulse_q;
  assign vactive_o    = vactive_q;
  assign locked_o     = locked_q;
  assign lost_o       = lost_q;

endmodule

// File: tb/tb_vga_rx.sv
// Self-checking bench for vga_rx: drives whole VGA frames built from a mode
// description, predicts lock/measurement behaviour frame by frame, and checks
// the pixel stream through a scoreboard queue.
`timescale 1ns/1ps
module tb_vga_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_i, vsync_i, blank_i;
  logic [3:0]  red_i, green_i, blue_i;
  logic [11:0] data_o;
  logic        data_valid_o;
  logic [10:0] x_o;
  logic [9:0]  y_o;
  logic        sof_o, eol_o;
  logic [10:0] htotal_o, hactive_o;
  logic [7:0]  hpulse_o;
  logic [9:0]  vtotal_o, vactive_o;
  logic [3:0]  vpulse_o;
  logic        locked_o, lost_o;

  vga_rx dut (
    .clk          (clk),
    .reset        (reset),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .blank_i      (blank_i),
    .red_i        (red_i),
    .green_i      (green_i),
    .blue_i       (blue_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .sof_o        (sof_o),
    .eol_o        (eol_o),
    .htotal_o     (htotal_o),
    .hpulse_o     (hpulse_o),
    .hactive_o    (hactive_o),
    .vtotal_o     (vtotal_o),
    .vpulse_o     (vpulse_o),
    .vactive_o    (vactive_o),
    .locked_o     (locked_o),
    .lost_o       (lost_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] htot;
    logic [7:0]  hpw;
    logic [10:0] hact;
    logic [9:0]  vtot;
    logic [3:0]  vpw;
    logic [9:0]  vact;
  } mode_t;

  typedef struct packed {
    logic [11:0] data;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
    logic        eol;
  } pix_t;

  localparam mode_t ModeA = '{htot: 11'd40, hpw: 8'd4, hact: 11'd16,
                              vtot: 10'd12, vpw: 4'd2, vact: 10'd8};
  localparam mode_t ModeB = '{htot: 11'd44, hpw: 8'd4, hact: 11'd16,
                              vtot: 10'd12, vpw: 4'd2, vact: 10'd8};

  pix_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          pix_seen = 0;
  int          sof_seen = 0;
  int          lost_cnt = 0;
  int unsigned lost_cyc = 0;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  logic        prev_hs = 1'b1;

  // Reference model: lock holds once two complete frames since the last restart
  // have identical timing; measurements show the last complete frame.
  int    nv = 0;
  bit    was_locked = 1'b0;
  mode_t last_m, prev_m, drv_m;

  logic [91:0] all_outs;
  assign all_outs = {data_o, data_valid_o, x_o, y_o, sof_o, eol_o, htotal_o, hpulse_o,
                     hactive_o, vtotal_o, vpulse_o, vactive_o, locked_o, lost_o};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    pix_t e, got;
    forever begin
      @(negedge clk);
      if (lost_o) begin
        lost_cnt++;
        lost_cyc = cyc;
      end
      if (data_valid_o) begin
        pix_seen++;
        if (sof_o) sof_seen++;
        got = {data_o, x_o, y_o, sof_o, eol_o};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pixel_unexpected got x=%0d y=%0d data=%h required=no pixel",
                   x_o, y_o, data_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL pixel got d=%h x=%0d y=%0d sof=%b eol=%b required d=%h x=%0d y=%0d sof=%b eol=%b",
                     got.data, got.x, got.y, got.sof, got.eol, e.data, e.x, e.y, e.sof, e.eol);
          end
        end
      end
    end
  end

  task automatic step(input logic hs, input logic vs, input logic bl, input logic [11:0] pix);
    @(posedge clk);
    #1;
    hsync_i = hs;
    vsync_i = vs;
    blank_i = bl;
    {blue_i, green_i, red_i} = pix;
    if (prev_hs && !hs) last_fall = cyc;
    prev_hs = hs;
  endtask

  task automatic restart_model();
    nv = 0;
    was_locked = 1'b0;
  endtask

  // Sync-only lines so the line counter is settled before the first vfall.
  task automatic preroll(input mode_t m);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < int'(m.htot); c++)
        step(!(c < int'(m.hpw)), 1'b1, 1'b0, 12'h000);
  endtask

  task automatic run_frame(input mode_t m, input bit pattern, input int reset_line);
    bit   lk, exp_lost;
    int   lost0, pix0, sof0, hstart, vstart, x, y;
    logic hs, vs, bl;
    logic [11:0] pix;
    pix_t e;
    nv++;
    if (nv >= 2) begin
      prev_m = last_m;
      last_m = drv_m;
    end
    lk       = (nv >= 3) && (prev_m == last_m);
    exp_lost = was_locked && !lk;
    drv_m    = m;
    lost0    = lost_cnt;
    pix0     = pix_seen;
    sof0     = sof_seen;
    hstart   = int'(m.hpw) + 8;
    vstart   = int'(m.vpw) + 1;
    for (int l = 0; l < int'(m.vtot); l++) begin
      for (int c = 0; c < int'(m.htot); c++) begin
        if (l == reset_line && c == hstart + 8) begin
          @(posedge clk);
          #1 reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          chk("midframe_reset_outputs", 128'(all_outs), 128'(0));
          @(posedge clk);
          #1 reset = 1'b0;
          exp_q.delete();
          restart_model();
          return;
        end
        x   = c - hstart;
        y   = l - vstart;
        hs  = !(c < int'(m.hpw));
        vs  = !(l < int'(m.vpw));
        bl  = (x >= 0) && (x < int'(m.hact)) && (y >= 0) && (y < int'(m.vact));
        pix = pattern ? {4'(y), 8'(x)} : 12'($urandom);
        step(hs, vs, bl, pix);
        if (bl && lk) begin
          e.data = pix;
          e.x    = 11'(x);
          e.y    = 10'(y);
          e.sof  = (x == 0) && (y == 0);
          e.eol  = (x == int'(m.hact) - 1);
          exp_q.push_back(e);
        end
        if (l == 0 && c == 6) begin
          chk("locked", 128'(locked_o), 128'(lk));
          chk("lost_pulses", 128'(lost_cnt - lost0), 128'(exp_lost));
          if (nv >= 2) begin
            chk("htotal", 128'(htotal_o), 128'(last_m.htot));
            chk("hpulse", 128'(hpulse_o), 128'(last_m.hpw));
            chk("hactive", 128'(hactive_o), 128'(last_m.hact));
            chk("vtotal", 128'(vtotal_o), 128'(last_m.vtot));
            chk("vpulse", 128'(vpulse_o), 128'(last_m.vpw));
            chk("vactive", 128'(vactive_o), 128'(last_m.vact));
          end
        end
      end
    end
    was_locked = lk;
    if (lk) begin
      chk("frame_pixels", 128'(pix_seen - pix0), 128'(int'(m.hact) * int'(m.vact)));
      chk("frame_sof", 128'(sof_seen - sof0), 128'(1));
      chk("frame_queue_empty", 128'(exp_q.size()), 128'(0));
    end
  endtask

  task automatic run_timeout(input int n);
    int lost0, dt;
    lost0 = lost_cnt;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 12'h000);
    chk("timeout_lost_pulses", 128'(lost_cnt - lost0), 128'(1));
    dt = int'(lost_cyc - last_fall);
    checks++;
    if (dt < 2045 || dt > 2055) begin
      failures++;
      $display("FAIL timeout_lost_time got=%0d clocks after hsync fall required=2045..2055", dt);
    end
    chk("timeout_locked", 128'(locked_o), 128'(0));
    chk("timeout_valid", 128'(data_valid_o), 128'(0));
    restart_model();
  endtask

  initial begin
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    blank_i = 1'b0;
    red_i   = '0;
    green_i = '0;
    blue_i  = '0;
    reset   = 1'b1;
    drv_m   = ModeA;
    last_m  = ModeA;
    prev_m  = ModeA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'(all_outs), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    restart_model();

    // Stable lock, {y,x} pattern, then random colour.
    preroll(ModeA);
    for (int f = 0; f < 4; f++) run_frame(ModeA, 1'b1, -1);
    for (int f = 0; f < 2; f++) run_frame(ModeA, 1'b0, -1);

    // Mode change to a 44-clock line.
    for (int f = 0; f < 4; f++) run_frame(ModeB, 1'b0, -1);

    // Hsync stuck high while locked.
    run_timeout(3000);

    // Relock, then reset during line 5 of a locked frame.
    preroll(ModeA);
    for (int f = 0; f < 3; f++) run_frame(ModeA, 1'b1, -1);
    run_frame(ModeA, 1'b0, 5);

    preroll(ModeA);
    for (int f = 0; f < 4; f++) run_frame(ModeA, 1'b0, -1);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 12'h000);
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
